// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the round-robin AXI write-path arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_M_MAX = 16;
  localparam int IDX_MAX_W = 4;

  // Priority-free encoder: assumes at most one bit of oh is set.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [NUM_M_MAX-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_M_MAX; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, scanning upward with wrap.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NUM_M-1:0] win,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] NUM_M_W = (IDX_W+1)'(NUM_M);

  logic [NUM_M-1:0] rot;
  logic [NUM_M-1:0] rot_first;
  logic [IDX_W-1:0] offs;
  logic [IDX_W:0]   sum;

  // Rotate so rr_ptr lands at bit 0, isolate the lowest set bit, then rotate the index back.
  assign rot       = NUM_M'({req, req} >> rr_ptr);
  assign rot_first = rot & (~rot + NUM_M'(1));
  assign offs      = IDX_W'(onehot_to_idx(NUM_M_MAX'(rot_first)));
  assign sum       = {1'b0, rr_ptr} + {1'b0, offs};
  assign idx       = (sum >= NUM_M_W) ? IDX_W'(sum - NUM_M_W) : sum[IDX_W-1:0];
  assign any       = |req;
  assign win       = any ? (NUM_M'(1) << idx) : '0;

endmodule

// File: rtl/axi_wr_arbiter_rr.sv
// N-master round-robin AXI write arbiter; grant held from AW/W until the B handshake.
// Optional high-priority subset selection enabled by defining AXI_WARB_HIPRI_EN.
module axi_wr_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter  int NUM_M = 4,
  localparam int IDX_W = $clog2(NUM_M)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_wvalid,
  input  logic [NUM_M-1:0] m_wlast,
  input  logic [NUM_M-1:0] m_bready,
  input  logic             s_awready,
  input  logic             s_wready,
  input  logic             s_bvalid,
`ifdef AXI_WARB_HIPRI_EN
  input  logic [NUM_M-1:0] m_hipri,
`endif
  output logic [NUM_M-1:0] wgrnt,
  output logic [IDX_W-1:0] wgrnt_idx,
  output logic             busy
);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             aw_done;
  logic             w_done;
  logic             aw_now;
  logic             w_now;
  logic             b_hs;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] pick_req;
  logic [NUM_M-1:0] pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign req = m_awvalid | m_wvalid;

`ifdef AXI_WARB_HIPRI_EN
  // High-priority requesters, when present, shadow everyone else but share rr_ptr.
  assign pick_req = (|(req & m_hipri)) ? (req & m_hipri) : req;
`else
  assign pick_req = req;
`endif

  rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr),
    .win    (pick_win),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Done flags fold in the current-cycle handshake so AW and WLAST may land in either order or together.
  assign aw_now = aw_done | (m_awvalid[wgrnt_idx] & s_awready);
  assign w_now  = w_done  | (m_wvalid[wgrnt_idx] & s_wready & m_wlast[wgrnt_idx]);
  assign b_hs   = s_bvalid & m_bready[wgrnt_idx];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      wgrnt     <= '0;
      wgrnt_idx <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            wgrnt     <= pick_win;
            wgrnt_idx <= pick_idx;
            busy      <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= XFER;
          end
        end
        XFER: begin
          aw_done <= aw_now;
          w_done  <= w_now;
          if (aw_now && w_now) state <= RESP;
        end
        RESP: begin
          // The B handshake closes the burst; the owner moves to the back of the rotation.
          if (b_hs) begin
            state   <= IDLE;
            wgrnt   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rr_ptr  <= (wgrnt_idx == IDX_W'(NUM_M-1)) ? '0 : wgrnt_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// Directed self-checking bench for axi_wr_arbiter_rr (NUM_M=4); hi-priority scenario with AXI_WARB_HIPRI_EN.
module tb_axi_wr_arbiter_rr;

  logic       ACLK;
  logic       ARESET;
  logic [3:0] m_awvalid;
  logic [3:0] m_wvalid;
  logic [3:0] m_wlast;
  logic [3:0] m_bready;
  logic       s_awready;
  logic       s_wready;
  logic       s_bvalid;
`ifdef AXI_WARB_HIPRI_EN
  logic [3:0] m_hipri;
`endif
  logic [3:0] wgrnt;
  logic [1:0] wgrnt_idx;
  logic       busy;

  int checks;
  int failures;

  axi_wr_arbiter_rr #(.NUM_M(4)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m_awvalid (m_awvalid),
    .m_wvalid  (m_wvalid),
    .m_wlast   (m_wlast),
    .m_bready  (m_bready),
    .s_awready (s_awready),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
`ifdef AXI_WARB_HIPRI_EN
    .m_hipri   (m_hipri),
`endif
    .wgrnt     (wgrnt),
    .wgrnt_idx (wgrnt_idx),
    .busy      (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // Single-beat burst of the current owner (AW and WLAST together), then B; ends back in IDLE.
  task automatic finish_burst(input logic [3:0] mask);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    m_wvalid  = mask;
    m_wlast   = mask;
    tick();
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_wvalid  = 4'b0000;
    m_wlast   = 4'b0000;
    s_bvalid  = 1'b1;
    m_bready  = mask;
    tick();
    s_bvalid  = 1'b0;
    m_bready  = 4'b0000;
  endtask

  task automatic test_reset;
    ARESET    = 1'b1;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_wlast   = '0;
    m_bready  = '0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
`ifdef AXI_WARB_HIPRI_EN
    m_hipri   = '0;
`endif
    tick();
    tick();
    ARESET = 1'b0;
    checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_wgrnt: got %b expected 0000", wgrnt); end
    checks++; if (wgrnt_idx !== 2'd0) begin failures++; $display("[TB] FAIL reset_idx: got %0d expected 0", wgrnt_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_first_grant;
    m_awvalid = 4'b1010;
    tick();
    checks++; if (wgrnt !== 4'b0010) begin failures++; $display("[TB] FAIL first_wgrnt: got %b expected 0010", wgrnt); end
    checks++; if (wgrnt_idx !== 2'd1) begin failures++; $display("[TB] FAIL first_idx: got %0d expected 1", wgrnt_idx); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL first_busy: got %b expected 1", busy); end
  endtask

  task automatic test_burst_rr;
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    m_wvalid  = 4'b0010;
    s_wready  = 1'b1;
    for (int beat = 1; beat <= 4; beat++) begin
      m_wlast = (beat == 4) ? 4'b0010 : 4'b0000;
      tick();
    end
    m_wvalid = 4'b0000;
    m_wlast  = 4'b0000;
    s_wready = 1'b0;
    checks++; if (wgrnt !== 4'b0010) begin failures++; $display("[TB] FAIL burst_hold_wgrnt: got %b expected 0010", wgrnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL burst_hold_busy: got %b expected 1", busy); end
    s_bvalid = 1'b1;
    m_bready = 4'b0010;
    tick();
    s_bvalid = 1'b0;
    m_bready = 4'b0000;
    checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL gap_wgrnt: got %b expected 0000", wgrnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL gap_busy: got %b expected 0", busy); end
    tick();
    checks++; if (wgrnt !== 4'b1000) begin failures++; $display("[TB] FAIL rr_next_wgrnt: got %b expected 1000", wgrnt); end
    checks++; if (wgrnt_idx !== 2'd3) begin failures++; $display("[TB] FAIL rr_next_idx: got %0d expected 3", wgrnt_idx); end
  endtask

  task automatic test_aw_w_same_cycle;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    m_wvalid  = 4'b1000;
    m_wlast   = 4'b1000;
    tick();
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_wvalid  = 4'b0000;
    m_wlast   = 4'b0000;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL same_busy: got %b expected 1", busy); end
    s_bvalid = 1'b1;
    m_bready = 4'b1000;
    tick();
    s_bvalid = 1'b0;
    m_bready = 4'b0000;
    checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL same_resp_release: got %b expected 0000", wgrnt); end
    tick();
    checks++; if (wgrnt !== 4'b0010) begin failures++; $display("[TB] FAIL wrap_wgrnt: got %b expected 0010", wgrnt); end
    checks++; if (wgrnt_idx !== 2'd1) begin failures++; $display("[TB] FAIL wrap_idx: got %0d expected 1", wgrnt_idx); end
  endtask

  task automatic test_w_before_aw;
    m_wvalid = 4'b0010;
    m_wlast  = 4'b0010;
    s_wready = 1'b1;
    tick();
    m_wvalid = 4'b0000;
    m_wlast  = 4'b0000;
    s_wready = 1'b0;
    tick();
    checks++; if (wgrnt !== 4'b0010) begin failures++; $display("[TB] FAIL wfirst_hold_wgrnt: got %b expected 0010", wgrnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wfirst_hold_busy: got %b expected 1", busy); end
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    s_bvalid  = 1'b1;
    m_bready  = 4'b0010;
    tick();
    s_bvalid  = 1'b0;
    m_bready  = 4'b0000;
    checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL wfirst_release_wgrnt: got %b expected 0000", wgrnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wfirst_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_burst;
    tick();
    checks++; if (wgrnt_idx !== 2'd3) begin failures++; $display("[TB] FAIL pre_reset_idx: got %0d expected 3", wgrnt_idx); end
    s_awready = 1'b1;
    s_wready  = 1'b1;
    m_wvalid  = 4'b1000;
    m_wlast   = 4'b1000;
    tick();
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_wvalid  = 4'b0000;
    m_wlast   = 4'b0000;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_wgrnt: got %b expected 0000", wgrnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (wgrnt_idx !== 2'd0) begin failures++; $display("[TB] FAIL midrst_idx: got %0d expected 0", wgrnt_idx); end
    m_awvalid = 4'b1111;
    tick();
    checks++; if (wgrnt !== 4'b0001) begin failures++; $display("[TB] FAIL post_rst_wgrnt: got %b expected 0001", wgrnt); end
    checks++; if (wgrnt_idx !== 2'd0) begin failures++; $display("[TB] FAIL post_rst_idx: got %0d expected 0", wgrnt_idx); end
  endtask

  task automatic test_all_request;
    logic [1:0] exp_idx;
    logic [3:0] exp_oh;
    for (int i = 1; i <= 4; i++) begin
      exp_idx = 2'(i % 4);
      exp_oh  = 4'b0001 << exp_idx;
      finish_burst(4'b1111);
      checks++; if (wgrnt !== 4'b0000) begin failures++; $display("[TB] FAIL all_gap_%0d: got %b expected 0000", i, wgrnt); end
      tick();
      checks++; if (wgrnt !== exp_oh) begin failures++; $display("[TB] FAIL all_wgrnt_%0d: got %b expected %b", i, wgrnt, exp_oh); end
      checks++; if (wgrnt_idx !== exp_idx) begin failures++; $display("[TB] FAIL all_idx_%0d: got %0d expected %0d", i, wgrnt_idx, exp_idx); end
    end
  endtask

`ifdef AXI_WARB_HIPRI_EN
  task automatic test_hipri;
    finish_burst(4'b1111);
    tick();
    checks++; if (wgrnt_idx !== 2'd1) begin failures++; $display("[TB] FAIL hp_setup1_idx: got %0d expected 1", wgrnt_idx); end
    finish_burst(4'b1111);
    tick();
    checks++; if (wgrnt_idx !== 2'd2) begin failures++; $display("[TB] FAIL hp_setup2_idx: got %0d expected 2", wgrnt_idx); end
    finish_burst(4'b1111);
    m_hipri = 4'b0100;
    tick();
    checks++; if (wgrnt_idx !== 2'd2) begin failures++; $display("[TB] FAIL hp_subset_idx: got %0d expected 2", wgrnt_idx); end
    checks++; if (wgrnt !== 4'b0100) begin failures++; $display("[TB] FAIL hp_subset_wgrnt: got %b expected 0100", wgrnt); end
    finish_burst(4'b1111);
    m_hipri = 4'b0000;
    tick();
    checks++; if (wgrnt_idx !== 2'd3) begin failures++; $display("[TB] FAIL hp_plain_idx: got %0d expected 3", wgrnt_idx); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_grant();
    test_burst_rr();
    test_aw_w_same_cycle();
    test_w_before_aw();
    test_reset_mid_burst();
    test_all_request();
`ifdef AXI_WARB_HIPRI_EN
    test_hipri();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
